// File: rtl/mseq_reseed_arbiter_pkg.sv
// Shared types and sizing helpers for the M-sequence reseed arbiter.
package mseq_arb_pkg;

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER, HOLDOFF} state_e;

  localparam int BCNT_W = 8;

  // Chaotic words needed to cover one seed.
  function automatic int words_f(input int iw, input int dw);
    return (iw + dw - 1) / dw;
  endfunction

  // Each n1_valid beat carries three words (x, y, z).
  function automatic int beats_f(input int words);
    return (words + 2) / 3;
  endfunction

endpackage

// File: rtl/mseq_reseed_arbiter_rr.sv
// Circular-priority one-hot pick: first requester strictly after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mseq_reseed_arbiter.sv
// Round-robin sharing of the chaotic x/y/z stream as packed seeds for a bank of M-sequence instances.
module mseq_reseed_arbiter
  import mseq_arb_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int INPUT_DATA_WIDTH = 288,
  parameter int NUM_REQ          = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        n1_valid,
  input  logic [DATA_WIDTH-1:0]       xn1,
  input  logic [DATA_WIDTH-1:0]       yn1,
  input  logic [DATA_WIDTH-1:0]       zn1,
  input  logic [NUM_REQ-1:0]          reseed_req,
  output logic [NUM_REQ-1:0]          reseed_gnt,
  output logic [INPUT_DATA_WIDTH-1:0] MSEQ_din,
  output logic [NUM_REQ-1:0]          MSEQ_din_valid,
  output logic                        busy,
  output logic [15:0]                 reseed_count
);

  localparam int WORDS = words_f(INPUT_DATA_WIDTH, DATA_WIDTH);
  localparam int BEATS = beats_f(WORDS);
  localparam int BEAT_W = 3 * DATA_WIDTH;
  localparam int BUF_W = BEATS * BEAT_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0]  pick;
  logic [BUF_W-1:0]    pack;
  logic [BUF_W-1:0]    pack_nxt;
  logic [BCNT_W-1:0]   bcnt;
  logic [15:0]         cnt_q;

  assign reseed_count = cnt_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req (reseed_req),
    .ptr (ptr),
    .gnt (pick)
  );

  // Oldest beat drifts toward the MSB end; x leads within a beat.
  generate
    if (BEATS == 1) begin : g_pack1
      assign pack_nxt = {xn1, yn1, zn1};
    end else begin : g_packn
      assign pack_nxt = {pack[BUF_W-BEAT_W-1:0], xn1, yn1, zn1};
    end
  endgenerate

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (reseed_gnt[i]) gnt_idx = PTR_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= PTR_W'(NUM_REQ - 1);
      reseed_gnt     <= '0;
      MSEQ_din       <= '0;
      MSEQ_din_valid <= '0;
      busy           <= 1'b0;
      cnt_q          <= '0;
      pack           <= '0;
      bcnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A beat landing on the grant cycle is deliberately dropped.
          if (|reseed_req) begin
            reseed_gnt <= pick;
            bcnt       <= '0;
            busy       <= 1'b1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          if (n1_valid) begin
            pack <= pack_nxt;
            if (bcnt == BCNT_W'(BEATS - 1)) begin
              MSEQ_din       <= pack_nxt[BUF_W-1 -: INPUT_DATA_WIDTH];
              MSEQ_din_valid <= reseed_gnt;
              state          <= DELIVER;
            end else begin
              bcnt <= bcnt + BCNT_W'(1);
            end
          end
        end
        DELIVER: begin
          MSEQ_din_valid <= '0;
          reseed_gnt     <= '0;
          ptr            <= gnt_idx;
          cnt_q          <= cnt_q + 16'd1;
          state          <= HOLDOFF;
        end
        HOLDOFF: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mseq_reseed_arbiter.sv
// Scoreboard bench: transaction-level reference model predicts grants and seed deliveries; a monitor checks them.
module tb_mseq_reseed_arbiter;

  localparam int DW    = 64;
  localparam int IW    = 288;
  localparam int N     = 4;
  localparam int WORDS = (IW + DW - 1) / DW;
  localparam int BEATS = (WORDS + 2) / 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          n1_valid = 1'b0;
  logic [DW-1:0] xn1 = '0, yn1 = '0, zn1 = '0;
  logic [N-1:0]  reseed_req = '0;
  logic [N-1:0]  reseed_gnt;
  logic [IW-1:0] MSEQ_din;
  logic [N-1:0]  MSEQ_din_valid;
  logic          busy;
  logic [15:0]   reseed_count;

  mseq_reseed_arbiter #(.DATA_WIDTH(DW), .INPUT_DATA_WIDTH(IW), .NUM_REQ(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .n1_valid       (n1_valid),
    .xn1            (xn1),
    .yn1            (yn1),
    .zn1            (zn1),
    .reseed_req     (reseed_req),
    .reseed_gnt     (reseed_gnt),
    .MSEQ_din       (MSEQ_din),
    .MSEQ_din_valid (MSEQ_din_valid),
    .busy           (busy),
    .reseed_count   (reseed_count)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int cyc; } gexp_t;
  typedef struct { int idx; logic [IW-1:0] seed; int cyc; logic [15:0] cnt; } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  int    dlog[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one transaction at a time, words accumulated in a queue.
  logic          m_act = 1'b0;
  int            m_ptr = N - 1;
  int            m_win = 0;
  int            m_idle_from = 0;
  logic [15:0]   m_cnt = '0;
  logic [DW-1:0] m_words[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 1'b0; m_ptr = N - 1; m_cnt = '0; m_idle_from = 0;
      m_words.delete();
    end else if (!m_act) begin
      if (cyc >= m_idle_from && reseed_req != '0) begin
        m_win = -1;
        for (int k = 1; k <= N; k++)
          if (m_win < 0 && reseed_req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
        gq.push_back('{m_win, cyc + 1});
        m_act = 1'b1;
        m_words.delete();
      end
    end else if (n1_valid) begin
      m_words.push_back(xn1); m_words.push_back(yn1); m_words.push_back(zn1);
      if (m_words.size() == 3 * BEATS) begin
        logic [WORDS*DW-1:0] big;
        big = '0;
        for (int i = 0; i < WORDS; i++) big = (big << DW) | (WORDS*DW)'(m_words[i]);
        m_cnt = m_cnt + 16'd1;
        dq.push_back('{m_win, big[WORDS*DW-1 -: IW], cyc + 1, m_cnt});
        m_ptr = m_win;
        m_act = 1'b0;
        m_idle_from = cyc + 3;
      end
    end
    cyc++;
  end

  // Monitor: compares DUT events against the model's predictions.
  logic [N-1:0] prev_gnt = '0;
  logic         cnt_pend = 1'b0;
  logic [15:0]  cnt_exp = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
      cnt_pend = 1'b0;
    end else begin
      if (!$onehot0(reseed_gnt)) chk("gnt_onehot", IW'(reseed_gnt), '0);
      if (!$onehot0(MSEQ_din_valid)) chk("dv_onehot", IW'(MSEQ_din_valid), '0);
      if (reseed_gnt != '0) chk("busy_with_gnt", IW'(busy), IW'(1));
      if (reseed_gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) chk("unexpected_gnt", IW'(reseed_gnt), '0);
        else begin
          gexp_t g;
          g = gq.pop_front();
          chk("gnt_value", IW'(reseed_gnt), IW'(1 << g.idx));
          chk("gnt_cycle", IW'(cyc), IW'(g.cyc));
        end
      end
      if (MSEQ_din_valid != '0) begin
        if (dq.size() == 0) chk("unexpected_dv", IW'(MSEQ_din_valid), '0);
        else begin
          dexp_t d;
          d = dq.pop_front();
          chk("dv_value", IW'(MSEQ_din_valid), IW'(1 << d.idx));
          chk("dv_gnt_match", IW'(reseed_gnt), IW'(1 << d.idx));
          chk("dv_cycle", IW'(cyc), IW'(d.cyc));
          chk("din_seed", MSEQ_din, d.seed);
          dlog.push_back(d.idx);
          cnt_pend = 1'b1;
          cnt_exp  = d.cnt;
        end
      end else if (cnt_pend) begin
        chk("reseed_count", IW'(reseed_count), IW'(cnt_exp));
        cnt_pend = 1'b0;
      end
      prev_gnt = reseed_gnt;
    end
  end

  task automatic wait_gnt();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reseed_gnt != '0) return;
    end
    chk("gnt_timeout", '0, IW'(1));
  endtask

  task automatic beat(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    n1_valid = 1'b1; xn1 = x; yn1 = y; zn1 = z;
    @(negedge clk);
    n1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    reseed_req = '0; n1_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, IW'(reseed_gnt), '0);
    chk({tag, "_din"}, MSEQ_din, '0);
    chk({tag, "_dv"}, IW'(MSEQ_din_valid), '0);
    chk({tag, "_busy"}, IW'(busy), '0);
    chk({tag, "_count"}, IW'(reseed_count), '0);
  endtask

  logic [6*DW-1:0] six;
  logic [IW-1:0]   seed_exp;
  int              rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single request with known words.
    reseed_req = 4'b0001;
    wait_gnt();
    beat(64'd1, 64'd2, 64'd3);
    beat(64'd4, 64'd5, 64'd6);
    reseed_req = '0;
    idle(4);
    six = {64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6};
    seed_exp = six[6*DW-1 -: IW];
    chk("single_din_const", MSEQ_din, seed_exp);
    chk("single_count", IW'(reseed_count), IW'(1));

    // Round robin from a fresh reset, all requesters held.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    dlog.delete();
    reseed_req = 4'b1111;
    for (int k = 0; k < 200 && dlog.size() < 5; k++) begin
      n1_valid = 1'b1; xn1 = {$urandom, $urandom}; yn1 = {$urandom, $urandom}; zn1 = {$urandom, $urandom};
      @(negedge clk);
    end
    idle(5);
    chk("rr_deliveries", IW'(dlog.size()), IW'(5));
    for (int i = 0; i < 5 && i < dlog.size(); i++) chk("rr_order", IW'(dlog[i]), IW'(rr_exp[i]));

    // Beat coincident with the grant decision must be ignored.
    reseed_req = 4'b0001;
    n1_valid = 1'b1; xn1 = 64'd9; yn1 = 64'd9; zn1 = 64'd9;
    @(negedge clk);
    n1_valid = 1'b0;
    beat(64'd7, 64'd8, 64'd9);
    beat(64'd10, 64'd11, 64'd12);
    reseed_req = '0;
    idle(4);
    six = {64'd7, 64'd8, 64'd9, 64'd10, 64'd11, 64'd12};
    seed_exp = six[6*DW-1 -: IW];
    chk("grant_beat_din", MSEQ_din, seed_exp);

    // Requester drops mid-collection; delivery still goes to it.
    reseed_req = 4'b0100;
    wait_gnt();
    beat(64'hA, 64'hB, 64'hC);
    reseed_req = '0;
    @(negedge clk);
    beat(64'hD, 64'hE, 64'hF);
    idle(4);
    chk("drop_busy_low", IW'(busy), '0);
    chk("drop_gnt_low", IW'(reseed_gnt), '0);

    // Reset mid-collection: outputs clear without waiting for a clock edge.
    reseed_req = 4'b0001;
    wait_gnt();
    beat(64'h11, 64'h22, 64'h33);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt();
    beat(64'h44, 64'h55, 64'h66);
    @(negedge clk);
    chk("midrst_no_early_dv", IW'(MSEQ_din_valid), '0);
    beat(64'h77, 64'h88, 64'h99);
    reseed_req = '0;
    idle(4);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) reseed_req = N'($urandom_range(0, (1 << N) - 1));
      n1_valid = ($urandom_range(0, 1) == 1);
      xn1 = {$urandom, $urandom}; yn1 = {$urandom, $urandom}; zn1 = {$urandom, $urandom};
      @(negedge clk);
    end
    idle(10);

    // Counter wrap via preload of the delivery counter.
    dut.cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    for (int r = 0; r < 2; r++) begin
      reseed_req = 4'b0010;
      wait_gnt();
      beat({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      beat({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      idle(4);
    end
    chk("wrap_count", IW'(reseed_count), '0);

    idle(20);
    chk("gq_drained", IW'(gq.size()), '0);
    chk("dq_drained", IW'(dq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mseq_reseed_arbiter.md
Name: mseq_reseed_arbiter

Overview:
- Shares the single chaotic generator output (x/y/z stream with n1_valid) between up to NUM_REQ M-sequence instances that request reseeding.
- Grants round-robin, packs the chaotic words into one INPUT_DATA_WIDTH seed, and pulses the granted instance's MSEQ_din_vld.
- Sits between the chaotic core and the top_M_sequence bank, in place of fixed one-instance seeding.

Parameters:
- DATA_WIDTH, 64, width of each chaotic state word xn1/yn1/zn1; must match the chaotic core.
- INPUT_DATA_WIDTH, 288, seed width required by each M-sequence instance.
- NUM_REQ, 4, number of M-sequence requesters (1..8).

Ports:
- clk  in  1  system clock (100 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- n1_valid  in  1  chaotic output beat valid, one-cycle pulse per beat.
- xn1  in  DATA_WIDTH  chaotic x state, valid with n1_valid.
- yn1  in  DATA_WIDTH  chaotic y state.
- zn1  in  DATA_WIDTH  chaotic z state.
- reseed_req  in  NUM_REQ  level request per M-sequence instance.
- reseed_gnt  out  NUM_REQ  one-hot grant, held from grant through delivery.
- MSEQ_din  out  INPUT_DATA_WIDTH  packed seed, held stable until the next delivery.
- MSEQ_din_valid  out  NUM_REQ  one-hot, one-cycle seed strobe to the granted instance.
- busy  out  1  high in every state except IDLE.
- reseed_count  out  16  completed deliveries, wraps 0xFFFF->0.

Behaviour:
- Constants: WORDS = ceil(INPUT_DATA_WIDTH/DATA_WIDTH) (5 at defaults); BEATS = ceil(WORDS/3) (2 at defaults).
- Reset (async, rst_n=0): state IDLE. reseed_gnt, MSEQ_din, MSEQ_din_valid, busy, reseed_count all 0. RR pointer = NUM_REQ-1, so req[0] has first priority.
- IDLE: if |reseed_req, register a one-hot grant for the first requester after the RR pointer (circular search), then move to COLLECT. reseed_gnt is high from the next cycle. n1_valid is ignored in IDLE.
- COLLECT: on each n1_valid, shift {xn1,yn1,zn1} into the pack buffer (BEATS*3*DATA_WIDTH bits). The first beat lands in the MSB end, and within a beat x is the most significant. The beat counter starts at 0 on entry. A beat coincident with the grant cycle (the IDLE cycle) is not counted. When the final beat is captured, load MSEQ_din with the top INPUT_DATA_WIDTH bits of the buffer including that beat; surplus low bits are discarded. Then go to DELIVER.
- DELIVER (1 cycle):
  - MSEQ_din_valid = reseed_gnt, with MSEQ_din already stable.
  - RR pointer moves to the granted index.
  - reseed_count increments.
  - reseed_gnt clears at the end of the cycle.
  - Next state HOLDOFF.
- HOLDOFF (1 cycle): no grant. Gives the served requester time to drop reseed_req. Next state IDLE.
- Latency: req rises in IDLE at cycle t -> gnt at t+1 -> din_valid one cycle after the BEATS-th counted n1_valid.
- A requester dropping req during COLLECT does not abort; the seed is still delivered to it.
- A requester still asserting req after HOLDOFF is re-arbitrated normally. With other requesters active it loses to them, because the pointer has advanced.
- A new req arriving during a non-IDLE state waits; there is no preemption.
- Reset mid-operation: immediate return to reset values; a partial pack buffer is discarded and no strobe is issued.
- MSEQ_din_valid and reseed_gnt are never multi-hot.

Decomposition:
- Package mseq_arb_pkg: state enum (IDLE, COLLECT, DELIVER, HOLDOFF); WORDS/BEATS computation functions; beat-counter width.
- One sub-module, rr_arbiter: NUM_REQ-wide circular priority pick. Inputs are the req vector and pointer; output is the one-hot grant; purely combinational.
- The top holds the FSM, pack buffer, pointer and counter.

Test Plan:
- Single request: req=4'b0001, n1_valid beats x/y/z=1,2,3 then 4,5,6 -> gnt=0001 the cycle after req. din_valid=0001 exactly one cycle after the 2nd beat. MSEQ_din = {64'd1,64'd2,64'd3,64'd4,64'd5}[319:32] (top 288 bits of {1..6}). reseed_count=1.
- Round robin: req=4'b1111 held, continuous beats -> delivery order 0,1,2,3,0. Exactly one HOLDOFF cycle between gnt fall and the next gnt rise.
- Grant-cycle beat: n1_valid asserted in the same cycle as the IDLE grant decision -> that beat is not packed; delivery occurs only after 2 later beats.
- Requester drop: req[2] only, deasserted mid-COLLECT -> seed still delivered with din_valid=0100; afterwards FSM returns to IDLE and busy falls.
- Reset mid-COLLECT: rst_n=0 after 1 beat -> all outputs 0 asynchronously, no din_valid. After release with req[0], a full 2-beat collection is required again.
- Counter wrap: force 65536 deliveries (or preload in the bench) -> reseed_count goes 0xFFFF -> 0x0000.
